// File: rtl/dwc_downconv_cmd_precalc_skid.sv
// AXI4 down-converter command pre-calculation stage: registers one address-channel
// command with its derived downsizing quantities behind a 2-entry skid buffer.
module dwc_downconv_cmd_precalc_skid #(
    parameter int unsigned DATA_WIDTH_IN  = 64,
    parameter int unsigned DATA_WIDTH_OUT = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned USER_WIDTH     = 1,
    localparam int unsigned CMD_W         = ID_WIDTH + ADDR_WIDTH + USER_WIDTH + 33
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  src_avalid,
    output logic                  src_aready,
    input  logic [CMD_W-1:0]      src_acmd,
    output logic                  dst_avalid,
    input  logic                  dst_aready,
    output logic [CMD_W-1:0]      dst_acmd,
    output logic [ADDR_WIDTH-1:0] pre_addr_mux,
    output logic [2:0]            pre_slv_size,
    output logic [5:0]            pre_size_max,
    output logic [5:0]            pre_size_cnt,
    output logic                  pre_same_size,
    output logic [5:0]            pre_mask_addr,
    output logic [12:0]           pre_tot_len,
    output logic [8:0]            pre_max_len,
    output logic [8:0]            pre_length,
    output logic [2:0]            pre_wrap_log,
    output logic [8:0]            pre_split_cnt,
    output logic                  idle
);

    localparam int unsigned LO_SIZE   = $clog2(DATA_WIDTH_OUT / 8);
    localparam int unsigned LI_SIZE   = $clog2(DATA_WIDTH_IN / 8);
    // Field offsets from the LSB; bits above AID are reserved and only passed through.
    localparam int unsigned BURST_LSB = USER_WIDTH + 17;
    localparam int unsigned SIZE_LSB  = USER_WIDTH + 19;
    localparam int unsigned LEN_LSB   = USER_WIDTH + 22;
    localparam int unsigned ADDR_LSB  = USER_WIDTH + 30;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr_mux;
        logic [2:0]            slv_size;
        logic [5:0]            size_max;
        logic [5:0]            size_cnt;
        logic                  same_size;
        logic [5:0]            mask_addr;
        logic [12:0]           tot_len;
        logic [8:0]            max_len;
        logic [8:0]            length;
        logic [2:0]            wrap_log;
        logic [8:0]            split_cnt;
    } pre_t;

    logic [2:0]            asize_raw;
    logic [2:0]            asize;
    logic [7:0]            alen;
    logic [1:0]            aburst;
    logic [ADDR_WIDTH-1:0] aaddr;
    logic                  reduce;
    logic                  is_fixed;
    logic                  is_wrap;
    logic                  is_incr;
    logic [2:0]            slv_size;
    logic [2:0]            size_diff;
    logic [8:0]            alen_p1;
    logic [7:0]            size_mask;
    logic [7:0]            low_off;
    logic [7:0]            low_cnt;
    logic [8:0]            len_offset;
    logic [12:0]           tot_aligned;
    logic [12:0]           tot_len;
    pre_t                  pre_c;

    // Derived downsizing quantities for the command presented on src_acmd.
    always_comb begin
        asize_raw   = src_acmd[SIZE_LSB +: 3];
        alen        = src_acmd[LEN_LSB +: 8];
        aburst      = src_acmd[BURST_LSB +: 2];
        aaddr       = src_acmd[ADDR_LSB +: ADDR_WIDTH];
        // Sizes wider than the master bus are illegal; clamp to keep shifts bounded.
        asize       = (asize_raw > 3'(LI_SIZE)) ? 3'(LI_SIZE) : asize_raw;
        is_fixed    = (aburst == 2'b00);
        is_wrap     = (aburst == 2'b10);
        is_incr     = !is_fixed && !is_wrap;
        reduce      = (asize > 3'(LO_SIZE));
        slv_size    = reduce ? 3'(LO_SIZE) : asize;
        size_diff   = asize - slv_size;
        alen_p1     = 9'(alen) + 9'd1;
        size_mask   = 8'((9'd1 << asize) - 9'd1);
        low_off     = {2'b00, aaddr[5:0]} & size_mask;
        low_cnt     = aaddr[7:0] & size_mask;
        len_offset  = reduce ? 9'(low_off >> LO_SIZE) : 9'd0;
        tot_aligned = 13'(alen_p1) << size_diff;
        tot_len     = is_incr ? (tot_aligned - 13'(len_offset)) : tot_aligned;

        pre_c           = '0;
        pre_c.slv_size  = slv_size;
        pre_c.size_max  = 6'((7'd1 << size_diff) - 7'd1);
        pre_c.size_cnt  = 6'(low_cnt >> slv_size);
        pre_c.same_size = !reduce;
        pre_c.mask_addr = 6'h3f << slv_size;
        pre_c.tot_len   = tot_len;
        pre_c.max_len   = is_incr  ? 9'd256 :
                          is_fixed ? (9'd1 << size_diff) : (9'd16 << size_diff);
        pre_c.length    = is_fixed ? (pre_c.max_len - len_offset) : pre_c.max_len;
        case (alen)
            8'd15:   pre_c.wrap_log = 3'd4;
            8'd7:    pre_c.wrap_log = 3'd3;
            8'd3:    pre_c.wrap_log = 3'd2;
            default: pre_c.wrap_log = 3'd1;
        endcase
        pre_c.addr_mux  = (is_fixed && reduce) ?
                          {aaddr[ADDR_WIDTH-1:6], aaddr[5:0] & pre_c.mask_addr} : aaddr;
        if (is_fixed) begin
            pre_c.split_cnt = alen_p1;
        end else if (is_wrap) begin
            pre_c.split_cnt = (tot_len[12:4] == 9'd0) ? 9'd1 : tot_len[12:4];
        end else begin
            pre_c.split_cnt = 9'(tot_len[12:8]) + 9'(tot_len[7:0] != 8'd0);
        end
    end

    logic             main_full_q, main_full_d;
    logic             skid_full_q, skid_full_d;
    logic [CMD_W-1:0] main_cmd_q, main_cmd_d;
    logic [CMD_W-1:0] skid_cmd_q, skid_cmd_d;
    pre_t             main_pre_q, main_pre_d;
    pre_t             skid_pre_q, skid_pre_d;
    logic             src_aready_q, src_aready_d;
    logic             idle_q, idle_d;
    logic             accept;

    // Skid-buffer steering: reload from skid first, else load main, else park in skid.
    always_comb begin
        main_full_d = main_full_q;
        skid_full_d = skid_full_q;
        main_cmd_d  = main_cmd_q;
        main_pre_d  = main_pre_q;
        skid_cmd_d  = skid_cmd_q;
        skid_pre_d  = skid_pre_q;
        accept      = src_avalid && src_aready_q;

        if (main_full_q && dst_aready && skid_full_q) begin
            main_cmd_d  = skid_cmd_q;
            main_pre_d  = skid_pre_q;
            skid_full_d = 1'b0;
        end else if (accept && (!main_full_q || dst_aready)) begin
            main_cmd_d  = src_acmd;
            main_pre_d  = pre_c;
            main_full_d = 1'b1;
        end else if (accept) begin
            skid_cmd_d  = src_acmd;
            skid_pre_d  = pre_c;
            skid_full_d = 1'b1;
        end else if (dst_aready) begin
            main_full_d = 1'b0;
        end

        src_aready_d = !skid_full_d;
        idle_d       = !main_full_d && !skid_full_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_full_q  <= 1'b0;
            skid_full_q  <= 1'b0;
            main_cmd_q   <= '0;
            skid_cmd_q   <= '0;
            main_pre_q   <= '0;
            skid_pre_q   <= '0;
            src_aready_q <= 1'b0;
            idle_q       <= 1'b1;
        end else begin
            main_full_q  <= main_full_d;
            skid_full_q  <= skid_full_d;
            main_cmd_q   <= main_cmd_d;
            skid_cmd_q   <= skid_cmd_d;
            main_pre_q   <= main_pre_d;
            skid_pre_q   <= skid_pre_d;
            src_aready_q <= src_aready_d;
            idle_q       <= idle_d;
        end
    end

    assign src_aready    = src_aready_q;
    assign dst_avalid    = main_full_q;
    assign dst_acmd      = main_cmd_q;
    assign idle          = idle_q;
    assign pre_addr_mux  = main_pre_q.addr_mux;
    assign pre_slv_size  = main_pre_q.slv_size;
    assign pre_size_max  = main_pre_q.size_max;
    assign pre_size_cnt  = main_pre_q.size_cnt;
    assign pre_same_size = main_pre_q.same_size;
    assign pre_mask_addr = main_pre_q.mask_addr;
    assign pre_tot_len   = main_pre_q.tot_len;
    assign pre_max_len   = main_pre_q.max_len;
    assign pre_length    = main_pre_q.length;
    assign pre_wrap_log  = main_pre_q.wrap_log;
    assign pre_split_cnt = main_pre_q.split_cnt;

endmodule

// File: tb/tb_dwc_downconv_cmd_precalc_skid.sv
// Bench for dwc_downconv_cmd_precalc_skid (IN=64, OUT=32): directed vectors,
// skid/stream/reset sequences, and random traffic against a queue model.
module tb_dwc_downconv_cmd_precalc_skid;

    localparam int unsigned AW = 32;
    localparam int unsigned IW = 4;
    localparam int unsigned UW = 1;
    localparam int unsigned CW = IW + AW + UW + 33;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          src_avalid;
    logic          src_aready;
    logic [CW-1:0] src_acmd;
    logic          dst_avalid;
    logic          dst_aready;
    logic [CW-1:0] dst_acmd;
    logic [AW-1:0] pre_addr_mux;
    logic [2:0]    pre_slv_size;
    logic [5:0]    pre_size_max;
    logic [5:0]    pre_size_cnt;
    logic          pre_same_size;
    logic [5:0]    pre_mask_addr;
    logic [12:0]   pre_tot_len;
    logic [8:0]    pre_max_len;
    logic [8:0]    pre_length;
    logic [2:0]    pre_wrap_log;
    logic [8:0]    pre_split_cnt;
    logic          idle;

    always #5 clk = ~clk;

    dwc_downconv_cmd_precalc_skid #(
        .DATA_WIDTH_IN (64),
        .DATA_WIDTH_OUT(32),
        .ADDR_WIDTH    (AW),
        .ID_WIDTH      (IW),
        .USER_WIDTH    (UW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_avalid   (src_avalid),
        .src_aready   (src_aready),
        .src_acmd     (src_acmd),
        .dst_avalid   (dst_avalid),
        .dst_aready   (dst_aready),
        .dst_acmd     (dst_acmd),
        .pre_addr_mux (pre_addr_mux),
        .pre_slv_size (pre_slv_size),
        .pre_size_max (pre_size_max),
        .pre_size_cnt (pre_size_cnt),
        .pre_same_size(pre_same_size),
        .pre_mask_addr(pre_mask_addr),
        .pre_tot_len  (pre_tot_len),
        .pre_max_len  (pre_max_len),
        .pre_length   (pre_length),
        .pre_wrap_log (pre_wrap_log),
        .pre_split_cnt(pre_split_cnt),
        .idle         (idle)
    );

    typedef struct {
        logic [12:0] tot_len;
        logic [8:0]  max_len;
        logic [8:0]  length;
        logic [8:0]  split;
        logic [5:0]  size_cnt;
        logic [5:0]  size_max;
        logic        same;
        logic [2:0]  wlog;
        logic [31:0] amux;
        logic [2:0]  slv;
        logic [5:0]  mask;
    } exp_t;

    typedef struct {
        logic [1:0]  burst;
        logic [2:0]  asize;
        logic [7:0]  alen;
        logic [31:0] addr;
        exp_t        e;
    } vec_t;

    typedef struct {
        logic [CW-1:0] cmd;
        exp_t          e;
    } item_t;

    int    checks = 0;
    int    failures = 0;
    vec_t  vecs[10];
    item_t q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_pre(input string tag, input exp_t e);
        chk({tag, ".tot_len"},   128'(pre_tot_len),   128'(e.tot_len));
        chk({tag, ".max_len"},   128'(pre_max_len),   128'(e.max_len));
        chk({tag, ".length"},    128'(pre_length),    128'(e.length));
        chk({tag, ".split_cnt"}, 128'(pre_split_cnt), 128'(e.split));
        chk({tag, ".size_cnt"},  128'(pre_size_cnt),  128'(e.size_cnt));
        chk({tag, ".size_max"},  128'(pre_size_max),  128'(e.size_max));
        chk({tag, ".same_size"}, 128'(pre_same_size), 128'(e.same));
        chk({tag, ".wrap_log"},  128'(pre_wrap_log),  128'(e.wlog));
        chk({tag, ".addr_mux"},  128'(pre_addr_mux),  128'(e.amux));
        chk({tag, ".slv_size"},  128'(pre_slv_size),  128'(e.slv));
        chk({tag, ".mask_addr"}, 128'(pre_mask_addr), 128'(e.mask));
    endtask

    function automatic logic [CW-1:0] mkc(input logic [1:0] burst, input logic [2:0] asize,
                                          input logic [7:0] alen, input logic [31:0] addr,
                                          input logic [3:0] id);
        return {3'b000, id, addr, alen, asize, burst, 2'b00, 4'h0, 3'h0, 4'h0, 4'h0, 1'b0};
    endfunction

    // Reference: the downsizing rules in plain integer arithmetic (slave beat = 4 bytes).
    function automatic exp_t ref_pre(input logic [1:0] burst, input int asize, input int alen,
                                     input logic [31:0] addr);
        exp_t e;
        int   slv, diff, off, tot, mx, lo8;
        bit   fixed, wrap, incr;
        fixed = (burst == 2'b00);
        wrap  = (burst == 2'b10);
        incr  = !fixed && !wrap;
        lo8   = int'(addr[7:0]);
        slv   = (asize > 2) ? 2 : asize;
        diff  = asize - slv;
        off   = (asize > 2) ? ((lo8 % 64) % (1 << asize)) / 4 : 0;
        tot   = (alen + 1) * (1 << diff) - (incr ? off : 0);
        mx    = incr ? 256 : (fixed ? (1 << diff) : 16 * (1 << diff));
        e.tot_len  = 13'(tot);
        e.max_len  = 9'(mx);
        e.length   = 9'(fixed ? mx - off : mx);
        e.split    = 9'(incr ? (tot + 255) / 256 : (fixed ? alen + 1 : ((tot / 16 < 1) ? 1 : tot / 16)));
        e.size_cnt = 6'((lo8 % (1 << asize)) / (1 << slv));
        e.size_max = 6'((1 << diff) - 1);
        e.same     = (diff == 0);
        e.mask     = 6'(64 - (1 << slv));
        e.wlog     = 3'((alen == 15) ? 4 : (alen == 7) ? 3 : (alen == 3) ? 2 : 1);
        e.slv      = 3'(slv);
        e.amux     = (fixed && diff != 0) ? addr - 32'(lo8 % (1 << slv)) : addr;
        return e;
    endfunction

    task automatic setv(input int i, input logic [1:0] b, input logic [2:0] s, input logic [7:0] l,
                        input logic [31:0] a, input int tot, input int mx, input int len,
                        input int sp, input int sc, input int sm, input int same, input int wl,
                        input logic [31:0] am, input int slv, input int mk);
        vecs[i].burst = b; vecs[i].asize = s; vecs[i].alen = l; vecs[i].addr = a;
        vecs[i].e.tot_len = 13'(tot); vecs[i].e.max_len = 9'(mx); vecs[i].e.length = 9'(len);
        vecs[i].e.split = 9'(sp); vecs[i].e.size_cnt = 6'(sc); vecs[i].e.size_max = 6'(sm);
        vecs[i].e.same = 1'(same); vecs[i].e.wlog = 3'(wl); vecs[i].e.amux = am;
        vecs[i].e.slv = 3'(slv); vecs[i].e.mask = 6'(mk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gen(output logic [CW-1:0] cmd, output exp_t e);
        logic [1:0]  b;
        int          s, l;
        logic [31:0] a;
        b = 2'($urandom_range(0, 3));
        s = int'($urandom_range(0, 3));
        if (b == 2'b10)      l = (1 << $urandom_range(1, 4)) - 1;
        else if (b == 2'b00) l = int'($urandom_range(0, 15));
        else                 l = int'($urandom_range(0, 255));
        a   = $urandom;
        cmd = {3'b000, 4'($urandom), a, 8'(l), 3'(s), b, 2'($urandom), 4'($urandom),
               3'($urandom), 4'($urandom), 4'($urandom), 1'($urandom)};
        e   = ref_pre(b, s, l, a);
    endtask

    initial begin
        logic [CW-1:0] ca, cb, cc, cr;
        logic [CW-1:0] sc[8];
        exp_t          er;
        item_t         it;
        bit            m_rdy;

        //         burst  sz    len     addr          tot  max  len  spl scnt smax same wl amux          slv mask
        setv(0, 2'b01, 3'd3, 8'd3,   32'h0000_1004,   7, 256, 256, 1, 1, 1, 0, 2, 32'h0000_1004, 2, 6'h3c);
        setv(1, 2'b00, 3'd3, 8'd1,   32'h0000_1004,   4,   2,   1, 2, 1, 1, 0, 1, 32'h0000_1004, 2, 6'h3c);
        setv(2, 2'b00, 3'd3, 8'd0,   32'h0000_1007,   2,   2,   1, 1, 1, 1, 0, 1, 32'h0000_1004, 2, 6'h3c);
        setv(3, 2'b01, 3'd3, 8'd255, 32'h0000_0000, 512, 256, 256, 2, 0, 1, 0, 1, 32'h0000_0000, 2, 6'h3c);
        setv(4, 2'b10, 3'd3, 8'd7,   32'h0000_0000,  16,  32,  32, 1, 0, 1, 0, 3, 32'h0000_0000, 2, 6'h3c);
        setv(5, 2'b01, 3'd2, 8'd15,  32'h0000_2002,  16, 256, 256, 1, 0, 0, 1, 4, 32'h0000_2002, 2, 6'h3c);
        setv(6, 2'b10, 3'd3, 8'd15,  32'h0000_0040,  32,  32,  32, 2, 0, 1, 0, 4, 32'h0000_0040, 2, 6'h3c);
        setv(7, 2'b01, 3'd0, 8'd0,   32'h0000_0003,   1, 256, 256, 1, 0, 0, 1, 1, 32'h0000_0003, 0, 6'h3f);
        setv(8, 2'b00, 3'd1, 8'd3,   32'h0000_0005,   4,   1,   1, 4, 0, 0, 1, 2, 32'h0000_0005, 1, 6'h3e);
        setv(9, 2'b11, 3'd3, 8'd3,   32'h0000_1004,   7, 256, 256, 1, 1, 1, 0, 2, 32'h0000_1004, 2, 6'h3c);

        // Reset held with a valid command pending.
        rst_n      = 1'b0;
        src_avalid = 1'b1;
        src_acmd   = mkc(2'b01, 3'd3, 8'd3, 32'h1004, 4'd5);
        dst_aready = 1'b0;
        #1;
        repeat (3) tick();
        chk("rst.aready",  128'(src_aready),  128'(0));
        chk("rst.dvalid",  128'(dst_avalid),  128'(0));
        chk("rst.idle",    128'(idle),        128'(1));
        chk("rst.acmd",    128'(dst_acmd),    128'(0));
        chk("rst.tot_len", 128'(pre_tot_len), 128'(0));
        chk("rst.addr",    128'(pre_addr_mux), 128'(0));
        rst_n      = 1'b1;
        src_avalid = 1'b0;
        chk("rst.aready_hold", 128'(src_aready), 128'(0));
        tick();
        chk("rst.aready_rise", 128'(src_aready), 128'(1));
        chk("rst.dvalid_after", 128'(dst_avalid), 128'(0));

        // Directed arithmetic vectors, one command each with the sink always ready.
        for (int i = 0; i < 10; i++) begin
            string tag;
            tag        = $sformatf("vec%0d", i);
            src_acmd   = mkc(vecs[i].burst, vecs[i].asize, vecs[i].alen, vecs[i].addr, 4'(i));
            src_avalid = 1'b1;
            dst_aready = 1'b1;
            tick();
            src_avalid = 1'b0;
            chk({tag, ".dvalid"}, 128'(dst_avalid), 128'(1));
            chk({tag, ".acmd"},   128'(dst_acmd),   128'(src_acmd));
            chk_pre(tag, vecs[i].e);
            tick();
            chk({tag, ".drained"}, 128'(dst_avalid), 128'(0));
        end

        // Back-pressure: A in main, B in skid, C held off; then drain in order.
        ca = mkc(2'b01, 3'd3, 8'd0, 32'h100, 4'd1);
        cb = mkc(2'b01, 3'd3, 8'd1, 32'h200, 4'd2);
        cc = mkc(2'b10, 3'd3, 8'd7, 32'h300, 4'd3);
        dst_aready = 1'b0;
        src_acmd   = ca;
        src_avalid = 1'b1;
        tick();
        chk("bp.a_main",   128'(dst_acmd),   128'(ca));
        chk("bp.a_ready",  128'(src_aready), 128'(1));
        src_acmd = cb;
        tick();
        chk("bp.b_skid_ready", 128'(src_aready), 128'(0));
        chk("bp.b_skid_main",  128'(dst_acmd),   128'(ca));
        chk("bp.b_skid_idle",  128'(idle),       128'(0));
        src_acmd = cc;
        tick();
        chk("bp.c_held_ready", 128'(src_aready), 128'(0));
        chk("bp.c_held_main",  128'(dst_acmd),   128'(ca));
        chk("bp.c_held_valid", 128'(dst_avalid), 128'(1));
        dst_aready = 1'b1;
        tick();
        chk("bp.b_out",       128'(dst_acmd),   128'(cb));
        chk("bp.b_out_valid", 128'(dst_avalid), 128'(1));
        chk("bp.b_out_ready", 128'(src_aready), 128'(1));
        tick();
        src_avalid = 1'b0;
        chk("bp.c_out",      128'(dst_acmd),     128'(cc));
        chk("bp.c_wrap_log", 128'(pre_wrap_log), 128'(3));
        chk("bp.c_tot_len",  128'(pre_tot_len),  128'(16));
        tick();
        chk("bp.empty_valid", 128'(dst_avalid), 128'(0));
        chk("bp.empty_idle",  128'(idle),       128'(1));

        // Streaming at one command per clock, then reset mid-stream.
        dst_aready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sc[i]      = mkc(2'b01, 3'd3, 8'(i), 32'h1000 + 32'(i * 8), 4'(i));
            src_acmd   = sc[i];
            src_avalid = 1'b1;
            tick();
            chk($sformatf("st%0d.aready", i), 128'(src_aready), 128'(1));
            chk($sformatf("st%0d.dvalid", i), 128'(dst_avalid), 128'(1));
            chk($sformatf("st%0d.acmd", i),   128'(dst_acmd),   128'(sc[i]));
        end
        rst_n = 1'b0;
        #1;
        chk("strst.dvalid", 128'(dst_avalid),  128'(0));
        chk("strst.idle",   128'(idle),        128'(1));
        chk("strst.aready", 128'(src_aready),  128'(0));
        chk("strst.acmd",   128'(dst_acmd),    128'(0));
        tick();
        rst_n      = 1'b1;
        src_avalid = 1'b0;
        dst_aready = 1'b0;
        tick();

        // Random traffic against the FIFO model (capacity two, ready while at most one held).
        m_rdy = 1'b1;
        for (int n = 0; n < 800; n++) begin
            chk("rnd.aready", 128'(src_aready), 128'(m_rdy));
            chk("rnd.dvalid", 128'(dst_avalid), 128'(q.size() != 0));
            chk("rnd.idle",   128'(idle),       128'(q.size() == 0));
            if (q.size() != 0) begin
                chk("rnd.acmd", 128'(dst_acmd), 128'(q[0].cmd));
                chk_pre("rnd", q[0].e);
            end
            gen(cr, er);
            src_acmd   = cr;
            src_avalid = ($urandom_range(0, 3) != 0);
            dst_aready = ($urandom_range(0, 2) != 0);
            if (dst_aready && q.size() != 0) void'(q.pop_front());
            if (src_avalid && m_rdy) begin
                it.cmd = cr;
                it.e   = er;
                q.push_back(it);
            end
            m_rdy = (q.size() <= 1);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
